// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive watchdog for the traffic light bus; checks
// encoding, phase order and per-phase dwell time, and counts completed cycles.
module traffic_light_monitor #(
  parameter int RED_MIN = 4,
  parameter int RED_MAX = 6,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 6,
  parameter int YELLOW_CYCLES = 2,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  light,
  input  logic        clr_err,
  output logic [1:0]  phase,
  output logic        err_illegal,
  output logic        err_seq,
  output logic        err_timing,
  output logic        err_sticky,
  output logic [15:0] cycles_done
);
  typedef enum logic [1:0] {SYNC, RED, GREEN, YELLOW} state_t;
  state_t state, code, succ;
  logic [CNT_W-1:0] dwell, max_d, min_d;
  logic unchecked, flagged, one_hot, short_exit, ill_e, seq_e, tim_e;
  assign phase = state;
  always_comb begin
    one_hot = light == 3'b100 || light == 3'b010 || light == 3'b001;
    code = light[2] ? RED : light[0] ? GREEN : YELLOW;
    succ = state == RED ? GREEN : state == GREEN ? YELLOW : RED;
    max_d = state == RED ? CNT_W'(RED_MAX) : state == GREEN ? CNT_W'(GREEN_MAX) : CNT_W'(YELLOW_CYCLES);
    min_d = state == RED ? CNT_W'(RED_MIN) : state == GREEN ? CNT_W'(GREEN_MIN) : CNT_W'(YELLOW_CYCLES);
    // an overrun phase was already reported; the first RED after SYNC has an unknown start
    short_exit = !flagged && !(state == RED && unchecked) && dwell < min_d;
    ill_e = !one_hot;
    seq_e = one_hot && state != SYNC && code != state && code != succ;
    tim_e = one_hot && state != SYNC && ((code == state && dwell == max_d) || (code == succ && short_exit));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
      dwell <= '0;
      unchecked <= 1'b0;
      flagged <= 1'b0;
      err_illegal <= 1'b0;
      err_seq <= 1'b0;
      err_timing <= 1'b0;
      err_sticky <= 1'b0;
      cycles_done <= '0;
    end else begin
      err_illegal <= ill_e;
      err_seq <= seq_e;
      err_timing <= tim_e;
      err_sticky <= ill_e || seq_e || tim_e || (err_sticky && !clr_err);
      if (!one_hot || seq_e) begin
        state <= SYNC;
        dwell <= '0;
      end else if (state == SYNC) begin
        if (code == RED) begin
          state <= RED;
          dwell <= CNT_W'(1);
          unchecked <= 1'b1;
          flagged <= 1'b0;
        end
      end else if (code == state) begin
        if (dwell != '1) dwell <= dwell + CNT_W'(1);
        if (dwell == max_d) flagged <= 1'b1;
      end else begin
        state <= code;
        dwell <= CNT_W'(1);
        unchecked <= 1'b0;
        flagged <= 1'b0;
        if (state == YELLOW && cycles_done != 16'hFFFF) cycles_done <= cycles_done + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: scoreboard bench; a behavioural reference pushes
// expected outputs per driven sample, popped and compared after the edge.
module tb_traffic_light_monitor;
  localparam logic [2:0] R = 3'b100, G = 3'b001, Y = 3'b010;
  typedef struct {
    int ph;
    int ill;
    int sq;
    int tm;
    int st;
    int cy;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, clr_err = 1'b0;
  logic [2:0] light = Y;
  logic [1:0] phase;
  logic err_illegal, err_seq, err_timing, err_sticky;
  logic [15:0] cycles_done;
  int errors = 0, checks = 0;
  exp_t sb[$];
  int m_st, m_dw, m_unc, m_flag, m_cyc, m_sticky;

  traffic_light_monitor dut (
    .clk(clk), .rst_n(rst_n), .light(light), .clr_err(clr_err), .phase(phase),
    .err_illegal(err_illegal), .err_seq(err_seq), .err_timing(err_timing),
    .err_sticky(err_sticky), .cycles_done(cycles_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_dw = 0; m_unc = 0; m_flag = 0; m_cyc = 0; m_sticky = 0;
  endtask

  // reference: 0 SYNC, 1 RED, 2 GREEN, 3 YELLOW
  function automatic exp_t predict(input logic [2:0] l, input logic c);
    exp_t e;
    int col, hi, lo;
    e = '{0, 0, 0, 0, 0, 0};
    col = l == R ? 1 : l == G ? 2 : l == Y ? 3 : 0;
    hi = m_st == 3 ? 2 : 6;
    lo = m_st == 3 ? 2 : 4;
    if (col == 0) begin
      e.ill = 1; m_st = 0; m_dw = 0;
    end else if (m_st == 0) begin
      if (col == 1) begin m_st = 1; m_dw = 1; m_unc = 1; m_flag = 0; end
    end else if (col == m_st) begin
      m_dw = m_dw < 255 ? m_dw + 1 : 255;
      if (m_dw == hi + 1) begin e.tm = 1; m_flag = 1; end
    end else if (col == m_st % 3 + 1) begin
      if (!m_flag && !(m_st == 1 && m_unc) && m_dw < lo) e.tm = 1;
      if (m_st == 3 && m_cyc < 65535) m_cyc++;
      m_st = col; m_dw = 1; m_flag = 0; m_unc = 0;
    end else begin
      e.sq = 1; m_st = 0; m_dw = 0;
    end
    m_sticky = (e.ill | e.sq | e.tm) | (m_sticky & !c);
    e.ph = m_st; e.st = m_sticky; e.cy = m_cyc;
    return e;
  endfunction

  task automatic step(input logic [2:0] l, input logic c = 1'b0);
    exp_t e;
    light = l; clr_err = c;
    sb.push_back(predict(l, c));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("phase", int'(phase), e.ph);
    check("err_illegal", int'(err_illegal), e.ill);
    check("err_seq", int'(err_seq), e.sq);
    check("err_timing", int'(err_timing), e.tm);
    check("err_sticky", int'(err_sticky), e.st);
    check("cycles_done", int'(cycles_done), e.cy);
  endtask

  task automatic run(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) step(l);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_errs"}, int'({err_illegal, err_seq, err_timing, err_sticky}), 0);
    check({tag, "_cycles"}, int'(cycles_done), 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    // clean sequence
    run(R, 5); run(G, 5); run(Y, 2); run(R, 1);
    check("clean_cycles", int'(cycles_done), 1);
    check("clean_sticky", int'(err_sticky), 0);
    // illegal value in GREEN, then unchecked short red
    run(R, 3); run(G, 2); step(3'b110);
    check("illegal_phase", int'(phase), 0);
    run(R, 2); run(G, 1);
    check("unchecked_exit", int'(err_timing), 0);
    // sequence error from RED
    run(G, 3); run(Y, 2); run(R, 1); step(Y);
    check("seq_pulse", int'(err_seq), 1);
    // overrun in GREEN, short yellow
    run(R, 5); run(G, 8); run(Y, 1); run(R, 1);
    check("short_yellow", int'(err_timing), 1);
    // clr_err colliding with err_seq, then lone clear
    step(Y, 1'b1);
    check("clr_vs_err", int'(err_sticky), 1);
    step(G, 1'b1);
    check("lone_clr", int'(err_sticky), 0);
    // random legal-heavy traffic
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 19);
      step(k < 6 ? R : k < 12 ? G : k < 17 ? Y : 3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
    end
    // async reset mid-GREEN
    run(Y, 1); run(R, 5); run(G, 2);
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(R, 5); run(G, 4); run(Y, 2); run(R, 1);
    check("post_reset_cycles", int'(cycles_done), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
